// File: rtl/cache_meta_array.sv
// Tag/valid metadata array for a set-associative cache with registered lookup,
// round-robin victim selection and a one-set-per-cycle invalidate sweep.
// Optional per-way dirty tracking is enabled with macro CACHE_META_DIRTY_EN.
module cache_meta_array #(
    parameter  int SETS  = 64,
    parameter  int WAYS  = 2,
    parameter  int TAG_W = 6,
    localparam int SET_W = $clog2(SETS),
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lk_en,
    input  logic [SET_W-1:0] lk_set,
    input  logic [TAG_W-1:0] lk_tag,
    output logic             hit_vld,
    output logic             hit,
    output logic [WAY_W-1:0] hit_way,
    output logic [WAY_W-1:0] victim_way,
    input  logic             fill_en,
    input  logic [SET_W-1:0] fill_set,
    input  logic [WAY_W-1:0] fill_way,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic             flush,
    output logic             busy,
`ifdef CACHE_META_DIRTY_EN
    input  logic             mark_dirty,
    output logic             victim_dirty,
`endif
    output logic             dbg_state_o
);

    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

    localparam logic [SET_W:0] SETS_L = (SET_W + 1)'(SETS);
    localparam logic [WAY_W:0] WAYS_L = (WAY_W + 1)'(WAYS);

    state_t           state_q, state_d;
    logic [SET_W-1:0] cnt_q, cnt_d;

    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAY_W-1:0] ptr_q   [SETS];

    logic             hit_vld_q, hit_vld_d;
    logic             hit_q, hit_d;
    logic [WAY_W-1:0] hit_way_q, hit_way_d;
    logic [WAY_W-1:0] victim_q, victim_d;

    logic             sweeping, lk_ok, fill_ok, lk_hit;
    logic [WAY_W-1:0] lk_way, lk_victim, fill_ptr;

    assign sweeping = (state_q == SWEEP);
    assign lk_ok    = ({1'b0, lk_set} < SETS_L);
    assign fill_ok  = fill_en && !sweeping && ({1'b0, fill_set} < SETS_L)
                      && ({1'b0, fill_way} < WAYS_L);
    assign fill_ptr = (WAYS == 1) ? '0 : WAY_W'(fill_way + 1'b1);

    // Descending scan: the last assignment wins, giving lowest-numbered way.
    always_comb begin
        lk_hit    = 1'b0;
        lk_way    = '0;
        lk_victim = '0;
        if (lk_ok) begin
            lk_victim = ptr_q[lk_set];
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag)) begin
                    lk_hit = 1'b1;
                    lk_way = WAY_W'(w);
                end
                if (!valid_q[lk_set][w]) begin
                    lk_victim = WAY_W'(w);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SET_W'(SETS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hit_vld_d = lk_en;
        hit_d     = 1'b0;
        hit_way_d = '0;
        victim_d  = '0;
        if (lk_en && !sweeping) begin
            hit_d     = lk_hit;
            hit_way_d = lk_way;
            victim_d  = lk_victim;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hit_vld_q <= 1'b0;
            hit_q     <= 1'b0;
            hit_way_q <= '0;
            victim_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hit_vld_q <= hit_vld_d;
            hit_q     <= hit_d;
            hit_way_q <= hit_way_d;
            victim_q  <= victim_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w] <= '0;
                end
            end
        end else if (sweeping) begin
            valid_q[cnt_q] <= '0;
            ptr_q[cnt_q]   <= '0;
        end else if (fill_ok) begin
            tag_q[fill_set][fill_way]   <= fill_tag;
            valid_q[fill_set][fill_way] <= 1'b1;
            ptr_q[fill_set]             <= fill_ptr;
        end
    end

`ifdef CACHE_META_DIRTY_EN
    logic [WAYS-1:0] dirty_q [SETS];
    logic            victim_dirty_q, victim_dirty_d;

    assign victim_dirty_d = lk_en && !sweeping && lk_ok && dirty_q[lk_set][lk_victim];

    // A fill in the same cycle as a mark to the same way leaves the way clean.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                dirty_q[s] <= '0;
            end
            victim_dirty_q <= 1'b0;
        end else begin
            victim_dirty_q <= victim_dirty_d;
            if (sweeping) begin
                dirty_q[cnt_q] <= '0;
            end else begin
                if (mark_dirty && lk_en && lk_hit) begin
                    dirty_q[lk_set][lk_way] <= 1'b1;
                end
                if (fill_ok) begin
                    dirty_q[fill_set][fill_way] <= 1'b0;
                end
            end
        end
    end

    assign victim_dirty = victim_dirty_q;
`endif

    assign hit_vld     = hit_vld_q;
    assign hit         = hit_q;
    assign hit_way     = hit_way_q;
    assign victim_way  = victim_q;
    assign busy        = sweeping;
    assign dbg_state_o = state_q;

endmodule
